response_demux_16: RTL and testbench

- 1-to-16 demultiplexing response collector for the PUF datapath; the write-side counterpart of the 16:1 response-select mux.
- Takes a serial stream of single PUF response bits and steers each bit into one of 16 slots of a response word.
- Slot choice is either an internal auto-stepping index or an externally supplied select.
- Presents the completed 16-bit word to the downstream consumer over a valid/ready handshake.

---
 rtl/response_demux_16.sv | 149 ++++++++++++++
 tb/tb_response_demux_16.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_demux_16.sv
// response_demux_16
//   Collects a serial stream of single PUF response bits into a 16-slot
//   response word and hands the completed word to a downstream consumer
//   over a valid/ready handshake.
//
//   Ports
//     clk        : rising-edge clock
//     rst        : asynchronous, active-high reset
//     start      : pulse that begins a new collection (also restarts one)
//     addr_mode  : 0 = sequential internal index, 1 = use wr_sel;
//                  latched on an accepted start
//     bit_in     : response bit to store
//     bit_valid  : bit_in / wr_sel valid this cycle
//     bit_ready  : collector accepts a bit this cycle (state COLLECT)
//     wr_sel     : target slot in addressed mode
//     word_out   : collected word, bit k = slot k
//     word_valid : word_out complete and stable (state FULL)
//     word_ready : consumer takes word_out
//     busy       : high while collecting
//     idx        : current sequential slot index (debug)
//
//   Parameter
//     LSB_FIRST  : 1 = sequential fill from slot 0 upward,
//                  0 = sequential fill from slot 15 downward
module response_demux_16 #(
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        addr_mode,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic        bit_ready,
  input  logic [3:0]  wr_sel,
  output logic [15:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic [3:0]  idx
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  localparam logic [3:0] IDX_INIT = (LSB_FIRST != 0) ? 4'd0 : 4'd15;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_word;
  logic [15:0] r_mask;
  logic [3:0]  r_idx;
  logic        r_mode;

  logic        w_do_start;
  logic        w_accept;
  logic [3:0]  w_sel;
  logic [15:0] w_mask_upd;

  // Slot targeted by an accept; mode is the one latched at start.
  assign w_sel      = r_mode ? wr_sel : r_idx;
  assign w_mask_upd = r_mask | (16'd1 << w_sel);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt = r_state;
    w_do_start  = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_do_start  = 1'b1;
          w_state_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // start has priority: a bit presented alongside a restart is dropped
        if (start) begin
          w_do_start  = 1'b1;
          w_state_nxt = S_COLLECT;
        end else if (bit_valid) begin
          w_accept = 1'b1;
          if (w_mask_upd == '1) begin
            w_state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        // start only counts when the word is taken in the same cycle,
        // which chains straight into the next collection
        if (word_ready) begin
          if (start) begin
            w_do_start  = 1'b1;
            w_state_nxt = S_COLLECT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: word, fill mask, sequential index, latched mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_mask <= '0;
      r_idx  <= IDX_INIT;
      r_mode <= 1'b0;
    end else if (w_do_start) begin
      r_word <= '0;
      r_mask <= '0;
      r_idx  <= IDX_INIT;
      r_mode <= addr_mode;
    end else if (w_accept) begin
      r_word[w_sel] <= bit_in;
      r_mask        <= w_mask_upd;
      if (!r_mode) begin
        if (LSB_FIRST != 0) begin
          r_idx <= r_idx + 4'd1;
        end else begin
          r_idx <= r_idx - 4'd1;
        end
      end
    end
  end

  assign bit_ready  = (r_state == S_COLLECT);
  assign busy       = (r_state == S_COLLECT);
  assign word_valid = (r_state == S_FULL);
  assign word_out   = r_word;
  assign idx        = r_idx;

endmodule

// File: tb/tb_response_demux_16.sv
module tb_response_demux_16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        addr_mode;
  logic        bit_in;
  logic        bit_valid;
  logic [3:0]  wr_sel;
  logic        word_ready;

  // index 0: LSB_FIRST=1 instance, index 1: LSB_FIRST=0 instance
  logic        bit_ready  [2];
  logic [15:0] word_out   [2];
  logic        word_valid [2];
  logic        busy       [2];
  logic [3:0]  idx        [2];

  int n_tests = 0;
  int n_fail  = 0;

  response_demux_16 #(.LSB_FIRST(1)) u_dut_lsb (
    .clk(clk), .rst(rst), .start(start), .addr_mode(addr_mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready[0]),
    .wr_sel(wr_sel), .word_out(word_out[0]), .word_valid(word_valid[0]),
    .word_ready(word_ready), .busy(busy[0]), .idx(idx[0])
  );

  response_demux_16 #(.LSB_FIRST(0)) u_dut_msb (
    .clk(clk), .rst(rst), .start(start), .addr_mode(addr_mode),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready[1]),
    .wr_sel(wr_sel), .word_out(word_out[1]), .word_valid(word_valid[1]),
    .word_ready(word_ready), .busy(busy[1]), .idx(idx[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slot contents, written-flags, pointer, activity
  // phase (0 idle, 1 collecting, 2 holding a full word)
  int m_slot  [2][16];
  int m_fill  [2][16];
  int m_ptr   [2];
  int m_mode  [2];
  int m_phase [2];

  function automatic int first_slot(input int m);
    return (m == 0) ? 0 : 15;
  endfunction

  function automatic logic [15:0] model_word(input int m);
    logic [15:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) if (m_slot[m][k] != 0) w[k] = 1'b1;
    return w;
  endfunction

  task automatic model_begin(input int m);
    for (int k = 0; k < 16; k++) begin
      m_slot[m][k] = 0;
      m_fill[m][k] = 0;
    end
    m_ptr[m]   = first_slot(m);
    m_mode[m]  = int'(addr_mode);
    m_phase[m] = 1;
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 16; k++) begin
        m_slot[m][k] = 0;
        m_fill[m][k] = 0;
      end
      m_ptr[m]   = first_slot(m);
      m_mode[m]  = 0;
      m_phase[m] = 0;
    end
  endtask

  task automatic model_step();
    int slot;
    int filled;
    for (int m = 0; m < 2; m++) begin
      if (m_phase[m] == 2) begin
        if (word_ready) begin
          if (start) model_begin(m);
          else m_phase[m] = 0;
        end
      end else if (start) begin
        model_begin(m);
      end else if (m_phase[m] == 1 && bit_valid) begin
        slot = (m_mode[m] != 0) ? int'(wr_sel) : m_ptr[m];
        m_slot[m][slot] = int'(bit_in);
        m_fill[m][slot] = 1;
        if (m_mode[m] == 0) m_ptr[m] = (m == 0) ? (m_ptr[m] + 1) % 16 : (m_ptr[m] + 15) % 16;
        filled = 0;
        for (int k = 0; k < 16; k++) filled += m_fill[m][k];
        if (filled == 16) m_phase[m] = 2;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("word_out[%0d]", m),   32'(word_out[m]),   32'(model_word(m)));
      check($sformatf("word_valid[%0d]", m), 32'(word_valid[m]), 32'(m_phase[m] == 2));
      check($sformatf("bit_ready[%0d]", m),  32'(bit_ready[m]),  32'(m_phase[m] == 1));
      check($sformatf("busy[%0d]", m),       32'(busy[m]),       32'(m_phase[m] == 1));
      check($sformatf("idx[%0d]", m),        32'(idx[m]),        32'(m_ptr[m]));
    end
  endtask

  task automatic drive(input logic st, input logic am, input logic bv,
                       input logic bi, input logic [3:0] sel, input logic wr);
    start = st; addr_mode = am; bit_valid = bv; bit_in = bi; wr_sel = sel; word_ready = wr;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  logic [15:0] pattern;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 4'd0, 0);
    #1;
    model_reset();
    compare_all();
    tick();
    rst = 1'b0;
    tick();

    // Sequential fill, pattern slot0..15 = 1,0,1,1,0,0,0,0,1,1,1,1,0,0,0,1
    pattern = 16'h8F0D;
    drive(1, 0, 1, 1, 4'd0, 0);   // bit with start is dropped
    tick();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, pattern[i], 4'd0, 0);
      tick();
      if (i == 14) check("seq_not_full_at_15", 32'(word_valid[0]), 32'd0);
    end
    drive(0, 0, 0, 0, 4'd0, 0);
    check("seq_valid_after_16", 32'(word_valid[0]), 32'd1);
    check("seq_word_lsb", 32'(word_out[0]), 32'h8F0D);
    check("seq_word_msb", 32'(word_out[1]), 32'hB0F1);
    check("seq_idx_lsb", 32'(idx[0]), 32'd0);
    check("seq_idx_msb", 32'(idx[1]), 32'd15);
    for (int i = 0; i < 5; i++) begin
      drive(i == 2, 0, 1, 1, 4'd0, 0);   // start and bits in FULL are ignored
      tick();
      check("hold_word", 32'(word_out[0]), 32'h8F0D);
      check("hold_bit_ready", 32'(bit_ready[0]), 32'd0);
    end
    drive(0, 0, 0, 0, 4'd0, 1);
    tick();
    check("handshake_idle", 32'(word_valid[0]), 32'd0);
    check("idle_word_held", 32'(word_out[0]), 32'h8F0D);

    // Addressed fill with an overwrite of slot 5 and slot 3 last
    drive(1, 1, 0, 0, 4'd0, 0);
    tick();
    for (int s = 15; s >= 0; s--) begin
      if (s == 3) continue;
      drive(0, 1, 1, 1, 4'(s), 0);
      tick();
    end
    drive(0, 0, 1, 0, 4'd5, 0);   // addr_mode here is not latched
    tick();
    check("addr_not_full", 32'(word_valid[0]), 32'd0);
    drive(0, 0, 1, 1, 4'd3, 0);
    tick();
    check("addr_full", 32'(word_valid[0]), 32'd1);
    check("addr_word", 32'(word_out[0]), 32'hFFDF);
    check("addr_word_msb", 32'(word_out[1]), 32'hFFDF);

    // FULL handshake with simultaneous start: no idle bubble
    drive(1, 0, 1, 1, 4'd0, 1);
    tick();
    check("chain_busy", 32'(busy[0]), 32'd1);
    check("chain_valid", 32'(word_valid[0]), 32'd0);
    check("chain_word", 32'(word_out[0]), 32'd0);
    check("chain_ready", 32'(bit_ready[0]), 32'd1);

    // Gapped sequential collection
    for (int i = 0; i < 40; i++) begin
      drive(0, 0, (i % 2) == 1, 1'($urandom), 4'($urandom), 0);
      tick();
    end
    check("gap_full", 32'(word_valid[0]), 32'd1);
    drive(0, 0, 0, 0, 4'd0, 1);
    tick();

    // Restart mid-collection
    drive(1, 0, 0, 0, 4'd0, 0);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 1, 4'd0, 0);
      tick();
    end
    drive(1, 0, 1, 1, 4'd0, 0);
    tick();
    check("restart_cleared", 32'(word_out[0]), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 4'd0, 0);
      tick();
      if (i == 14) check("restart_not_full", 32'(word_valid[0]), 32'd0);
    end
    check("restart_full", 32'(word_valid[0]), 32'd1);
    check("restart_word", 32'(word_out[0]), 32'd0);
    drive(0, 0, 0, 0, 4'd0, 1);
    tick();

    // Async reset between edges, mid-collection
    drive(1, 0, 0, 0, 4'd0, 0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 1, 4'd0, 0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("async_word", 32'(word_out[0]), 32'd0);
    check("async_busy", 32'(busy[0]), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 1, 4'd0, 0);
      tick();
    end
    check("no_start_ignored", 32'(word_out[1]), 32'd0);
    drive(1, 0, 0, 0, 4'd0, 0);
    tick();
    drive(0, 0, 1, 1, 4'd0, 0);
    tick();
    check("msb_first_slot", 32'(word_out[1]), 32'h8000);
    check("lsb_first_slot", 32'(word_out[0]), 32'h0001);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 19) == 0), 1'($urandom), ($urandom_range(0, 9) < 7),
            1'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
